// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Imported by the loader RTL, the CPU system and the testbench.
package imem_loader_pkg;

    localparam int DEPTH_WORDS_DEF = 64;
    localparam int ADDR_W          = 8;
    localparam int CNT_W           = 7;
    localparam int DATA_W          = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } ld_state_e;

    // Byte lane (0 = bits [7:0]) that a given byte index lands in.
    function automatic logic [1:0] lane_of(input logic [1:0] idx,
                                           input bit be);
        return be ? (2'd3 - idx) : idx;
    endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// Packs the incoming byte stream into 32-bit words.
// Holds the byte index and the assembly register.
module imem_loader_assembler
    import imem_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              take,
    input  logic [7:0]        byte_in,
    output logic              idx_last,
    output logic [DATA_W-1:0] word_nxt
);

    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic [1:0]        lane;

    assign lane = lane_of(idx_q, BIG_ENDIAN);

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr) begin
            idx_d  = 2'd0;
            word_d = '0;
        end else if (take) begin
            word_d[{lane, 3'b000} +: 8] = byte_in;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    // The owner latches the completed word on the same edge as byte 3.
    assign idx_last = (idx_q == 2'd3);
    assign word_nxt = word_d;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams program bytes into instruction memory
// while holding the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              LD_start,
    input  logic              LD_byte_valid,
    input  logic [7:0]        LD_byte,
    input  logic              LD_last,
    output logic              LD_byte_ready,
    output logic              IMEM_wr_en,
    output logic [ADDR_W-1:0] IMEM_wr_addr,
    output logic [DATA_W-1:0] IMEM_wr_data,
    output logic              LD_cpu_hold,
    output logic              LD_done,
    output logic              LD_error,
    output logic [CNT_W-1:0]  LD_word_count
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;
    logic              hold_q, hold_d;
    logic              wen_q, wen_d;

    logic              take;
    logic              asm_clr;
    logic              idx_last;
    logic [DATA_W-1:0] word_nxt;

    assign take    = LD_byte_valid & rdy_q;
    assign cnt_inc = cnt_q + 1'b1;

    imem_loader_assembler #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clk      (SYS_clk),
        .rst      (SYS_reset),
        .clr      (asm_clr),
        .take     (take),
        .byte_in  (LD_byte),
        .idx_last (idx_last),
        .word_nxt (word_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
        asm_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (LD_start) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    asm_clr = 1'b1;
                end
            end
            ST_RECV: begin
                if (take) begin
                    if (idx_last) begin
                        state_d = ST_WRITE;
                        data_d  = word_nxt;
                        addr_d  = ADDR_W'({cnt_q, 2'b00});
                        last_d  = LD_last;
                    end else if (LD_last) begin
                        // Program ended mid-word: abort without a write.
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_inc;
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (cnt_inc == DEPTH_CNT) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and strobe outputs are decoded from the next state
    // so they are flops aligned with the state they describe.
    always_comb begin
        rdy_d  = (state_d == ST_RECV);
        hold_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
        wen_d  = (state_d == ST_WRITE);
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            hold_q  <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            hold_q  <= hold_d;
            wen_q   <= wen_d;
        end
    end

    assign LD_byte_ready = rdy_q;
    assign IMEM_wr_en    = wen_q;
    assign IMEM_wr_addr  = addr_q;
    assign IMEM_wr_data  = data_q;
    assign LD_cpu_hold   = hold_q;
    assign LD_done       = done_q;
    assign LD_error      = err_q;
    assign LD_word_count = cnt_q;

endmodule
